// File: rtl/dpb_slot_scheduler.sv
// Hands out 4 DPB frame slots to one producer and one consumer strictly in ring order, with a fill timeout.
// Grant, offer and level respond one cycle after their cause; a full ring withholds grants and an empty ring withholds offers.
module dpb_slot_scheduler #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
   parameter int          SLOTS       = 4
) (
   input  logic        i_clk50m,
   input  logic        i_rst,
   input  logic        i_wr_req,
   output logic        o_wr_grant,
   output logic [1:0]  o_wr_slot,
   output logic [31:0] o_wr_seq,
   input  logic        i_wr_done,
   input  logic        i_wr_abort,
   output logic        o_wr_timeout,
   output logic        o_rd_valid,
   output logic [1:0]  o_rd_slot,
   input  logic        i_rd_ack,
   input  logic        i_rd_done,
   output logic [2:0]  o_level,
   output logic        o_full,
   output logic        o_empty
);

   localparam logic [2:0] LVL_MAX = 3'(SLOTS);

   typedef enum logic {W_IDLE, W_FILL} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_OFFER, R_BUSY} rd_state_e;

   wr_state_e   wr_state_q, wr_state_d;
   rd_state_e   rd_state_q, rd_state_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0] seq_q, seq_d;
   logic [2:0]  level_q, level_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        grant_q, grant_d;

   logic full;
   logic commit;
   logic tmo_hit;
   logic release_slot;

   always_ff @(posedge i_clk50m) begin
      if (i_rst) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         seq_q      <= 32'd0;
         level_q    <= 3'd0;
         tmo_cnt_q  <= 16'd0;
         grant_q    <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         seq_q      <= seq_d;
         level_q    <= level_d;
         tmo_cnt_q  <= tmo_cnt_d;
         grant_q    <= grant_d;
      end
   end

   // Done outranks both abort and timeout in the same cycle.
   always_comb begin
      full         = (level_q == LVL_MAX);
      commit       = (wr_state_q == W_FILL) && i_wr_done;
      tmo_hit      = (wr_state_q == W_FILL) && !i_wr_done && !i_wr_abort &&
                     (tmo_cnt_q == TIMEOUT_CYC - 16'd1);
      release_slot = (rd_state_q == R_BUSY) && i_rd_done;
      grant_d      = (wr_state_q == W_IDLE) && i_wr_req && !full;

      wr_state_d = wr_state_q;
      tmo_cnt_d  = 16'd0;
      case (wr_state_q)
         W_IDLE: begin
            if (grant_d) begin
               wr_state_d = W_FILL;
            end
         end
         W_FILL: begin
            if (commit || i_wr_abort || tmo_hit) begin
               wr_state_d = W_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase

      rd_state_d = rd_state_q;
      case (rd_state_q)
         R_IDLE:  if (level_q != 3'd0) rd_state_d = R_OFFER;
         R_OFFER: if (i_rd_ack)        rd_state_d = R_BUSY;
         R_BUSY:  if (i_rd_done)       rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase

      wr_ptr_d = commit ? wr_ptr_q + 2'd1 : wr_ptr_q;
      seq_d    = commit ? seq_q + 32'd1 : seq_q;
      rd_ptr_d = release_slot ? rd_ptr_q + 2'd1 : rd_ptr_q;

      case ({commit, release_slot})
         2'b10:   level_d = level_q + 3'd1;
         2'b01:   level_d = level_q - 3'd1;
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      o_wr_grant   = grant_q;
      o_wr_slot    = wr_ptr_q;
      o_wr_seq     = seq_q;
      o_wr_timeout = tmo_hit;
      o_rd_valid   = (rd_state_q == R_OFFER);
      o_rd_slot    = rd_ptr_q;
      o_level      = level_q;
      o_full       = full;
      o_empty      = (level_q == 3'd0);
   end

endmodule

// File: tb/tb_dpb_slot_scheduler.sv
// Directed bench for dpb_slot_scheduler with a short fill timeout.
module tb_dpb_slot_scheduler;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_wr_req = 1'b0;
   logic        i_wr_done = 1'b0;
   logic        i_wr_abort = 1'b0;
   logic        i_rd_ack = 1'b0;
   logic        i_rd_done = 1'b0;
   logic        o_wr_grant;
   logic [1:0]  o_wr_slot;
   logic [31:0] o_wr_seq;
   logic        o_wr_timeout;
   logic        o_rd_valid;
   logic [1:0]  o_rd_slot;
   logic [2:0]  o_level;
   logic        o_full;
   logic        o_empty;

   int n_assert = 0;
   int n_fail   = 0;

   dpb_slot_scheduler #(.TIMEOUT_CYC(16'd16)) dut (
      .i_clk50m    (clk),
      .i_rst       (i_rst),
      .i_wr_req    (i_wr_req),
      .o_wr_grant  (o_wr_grant),
      .o_wr_slot   (o_wr_slot),
      .o_wr_seq    (o_wr_seq),
      .i_wr_done   (i_wr_done),
      .i_wr_abort  (i_wr_abort),
      .o_wr_timeout(o_wr_timeout),
      .o_rd_valid  (o_rd_valid),
      .o_rd_slot   (o_rd_slot),
      .i_rd_ack    (i_rd_ack),
      .i_rd_done   (i_rd_done),
      .o_level     (o_level),
      .o_full      (o_full),
      .o_empty     (o_empty)
   );

   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_grant"},   32'(o_wr_grant),   32'd0);
      chk({tag, "_wslot"},   32'(o_wr_slot),    32'd0);
      chk({tag, "_seq"},     o_wr_seq,          32'd0);
      chk({tag, "_tmo"},     32'(o_wr_timeout), 32'd0);
      chk({tag, "_rvalid"},  32'(o_rd_valid),   32'd0);
      chk({tag, "_rslot"},   32'(o_rd_slot),    32'd0);
      chk({tag, "_level"},   32'(o_level),      32'd0);
      chk({tag, "_full"},    32'(o_full),       32'd0);
      chk({tag, "_empty"},   32'(o_empty),      32'd1);
   endtask

   // Request in W_IDLE with room: grant must appear after exactly one edge, then commit.
   task automatic wr_fill(input logic [1:0] exp_slot, input logic [31:0] exp_seq);
      i_wr_req = 1'b1;
      tick();
      chk("fill_grant", 32'(o_wr_grant), 32'd1);
      chk("fill_slot",  32'(o_wr_slot),  32'(exp_slot));
      chk("fill_seq",   o_wr_seq,        exp_seq);
      i_wr_req  = 1'b0;
      i_wr_done = 1'b1;
      tick();
      i_wr_done = 1'b0;
   endtask

   task automatic rd_take(input logic [1:0] exp_slot);
      for (int k = 0; k < 4 && !o_rd_valid; k++) tick();
      chk("take_valid", 32'(o_rd_valid), 32'd1);
      chk("take_slot",  32'(o_rd_slot),  32'(exp_slot));
      i_rd_ack = 1'b1;
      tick();
      i_rd_ack = 1'b0;
      chk("take_busy_valid", 32'(o_rd_valid), 32'd0);
      chk("take_busy_slot",  32'(o_rd_slot),  32'(exp_slot));
      i_rd_done = 1'b1;
      tick();
      i_rd_done = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic early_tmo;

      tick();
      tick();
      chk_reset_outputs("reset");

      // Fill all four slots with no consumer; grant available right after release.
      i_rst = 1'b0;
      for (int s = 0; s < 4; s++) wr_fill(2'(s), 32'(s));
      chk("full_level", 32'(o_level), 32'd4);
      chk("full_full",  32'(o_full),  32'd1);
      chk("full_empty", 32'(o_empty), 32'd0);
      chk("full_rslot", 32'(o_rd_slot), 32'd0);

      i_wr_req = 1'b1;
      tick();
      chk("full_nogrant0", 32'(o_wr_grant), 32'd0);
      tick();
      chk("full_nogrant1", 32'(o_wr_grant), 32'd0);

      // Release slot 0 while request is pending.
      rd_take(2'd0);
      chk("rel_level", 32'(o_level), 32'd3);
      chk("rel_full",  32'(o_full),  32'd0);
      chk("rel_nogrant", 32'(o_wr_grant), 32'd0);
      tick();
      chk("regrant",      32'(o_wr_grant), 32'd1);
      chk("regrant_slot", 32'(o_wr_slot),  32'd0);
      chk("regrant_seq",  o_wr_seq,        32'd4);
      chk("reoffer_slot", 32'(o_rd_slot),  32'd1);
      i_wr_req  = 1'b0;
      i_wr_done = 1'b1;
      tick();
      i_wr_done = 1'b0;
      chk("recommit_level", 32'(o_level), 32'd4);

      rd_take(2'd1);
      rd_take(2'd2);
      chk("drain_level", 32'(o_level), 32'd2);
      wr_fill(2'd1, 32'd5);
      chk("pre_abort_level", 32'(o_level), 32'd3);

      // Abort leaves pointer, sequence and level untouched.
      i_wr_req = 1'b1;
      tick();
      chk("ab_grant", 32'(o_wr_grant), 32'd1);
      chk("ab_slot",  32'(o_wr_slot),  32'd2);
      chk("ab_seq",   o_wr_seq,        32'd6);
      i_wr_req   = 1'b0;
      i_wr_abort = 1'b1;
      tick();
      i_wr_abort = 1'b0;
      chk("ab_level", 32'(o_level), 32'd3);
      chk("ab_seq_after", o_wr_seq, 32'd6);

      // Reissued slot 2, then let it time out after 15 cycles.
      i_wr_req = 1'b1;
      tick();
      chk("tg_grant", 32'(o_wr_grant), 32'd1);
      chk("tg_slot",  32'(o_wr_slot),  32'd2);
      chk("tg_seq",   o_wr_seq,        32'd6);
      i_wr_req = 1'b0;
      early_tmo = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (o_wr_timeout) early_tmo = 1'b1;
      end
      chk("tmo_early", 32'(early_tmo), 32'd0);
      tick();
      chk("tmo_pulse", 32'(o_wr_timeout), 32'd1);
      i_wr_req = 1'b1;
      tick();
      chk("tmo_gone",    32'(o_wr_timeout), 32'd0);
      chk("tmo_nogrant", 32'(o_wr_grant),   32'd0);
      chk("tmo_level",   32'(o_level),      32'd3);
      tick();
      chk("tmo_regrant", 32'(o_wr_grant), 32'd1);
      chk("tmo_reslot",  32'(o_wr_slot),  32'd2);
      chk("tmo_reseq",   o_wr_seq,        32'd6);
      i_wr_req  = 1'b0;
      i_wr_done = 1'b1;
      tick();
      i_wr_done = 1'b0;
      chk("tmo_commit_level", 32'(o_level), 32'd4);

      // Reach level 2, then commit (done+abort together) and release in one cycle.
      rd_take(2'd3);
      rd_take(2'd0);
      chk("sim_pre_level", 32'(o_level), 32'd2);
      i_wr_req = 1'b1;
      tick();
      chk("sim_grant_slot", 32'(o_wr_slot), 32'd3);
      chk("sim_grant_seq",  o_wr_seq,       32'd7);
      chk("sim_offer",      32'(o_rd_valid), 32'd1);
      chk("sim_offer_slot", 32'(o_rd_slot),  32'd1);
      i_wr_req = 1'b0;
      i_rd_ack = 1'b1;
      tick();
      i_rd_ack   = 1'b0;
      i_wr_done  = 1'b1;
      i_wr_abort = 1'b1;
      i_rd_done  = 1'b1;
      tick();
      i_wr_done  = 1'b0;
      i_wr_abort = 1'b0;
      i_rd_done  = 1'b0;
      chk("sim_level", 32'(o_level),   32'd2);
      chk("sim_seq",   o_wr_seq,       32'd8);
      chk("sim_wptr",  32'(o_wr_slot), 32'd0);
      chk("sim_rptr",  32'(o_rd_slot), 32'd2);

      // Level 3 with consumer busy, then reset mid-read.
      wr_fill(2'd0, 32'd8);
      for (int k = 0; k < 4 && !o_rd_valid; k++) tick();
      chk("rb_offer_slot", 32'(o_rd_slot), 32'd2);
      i_rd_ack = 1'b1;
      tick();
      i_rd_ack = 1'b0;
      chk("rb_busy_valid", 32'(o_rd_valid), 32'd0);
      chk("rb_level", 32'(o_level), 32'd3);
      i_rst = 1'b1;
      tick();
      chk_reset_outputs("midrst");

      // Stray completion pulses in idle states must be ignored.
      i_rst     = 1'b0;
      i_wr_done = 1'b1;
      i_rd_done = 1'b1;
      i_rd_ack  = 1'b1;
      tick();
      i_wr_done = 1'b0;
      i_rd_done = 1'b0;
      i_rd_ack  = 1'b0;
      chk("stray_level", 32'(o_level), 32'd0);
      chk("stray_seq",   o_wr_seq,     32'd0);
      chk("stray_empty", 32'(o_empty), 32'd1);
      i_wr_req = 1'b1;
      tick();
      chk("post_grant", 32'(o_wr_grant), 32'd1);
      chk("post_slot",  32'(o_wr_slot),  32'd0);
      chk("post_seq",   o_wr_seq,        32'd0);
      i_wr_req = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dpb_slot_scheduler.md
DPB_SLOT_SCHEDULER -- requirements
Module: dpb_slot_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd50000: W_FILL cycles without done/abort before forced abort.
REQ-002 Parameter SLOTS, fixed 4: DPB frame slots, addressed by 2-bit slot index (upper DPB address bits).
REQ-003 i_clk50m  in  1  sole clock; all logic on its rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_wr_req  in  1  producer requests a free slot; level, held until grant.
REQ-006 o_wr_grant  out  1  one-cycle pulse; slot in o_wr_slot now owned by producer.
REQ-007 o_wr_slot  out  2  slot index being filled; valid from grant until commit/abort.
REQ-008 o_wr_seq  out  32  sequence number producer writes into the slot header word [31:0].
REQ-009 i_wr_done  in  1  one-cycle pulse; producer finished slot, commit.
REQ-010 i_wr_abort  in  1  one-cycle pulse; producer abandons slot, no commit.
REQ-011 o_wr_timeout  out  1  one-cycle pulse on forced abort.
REQ-012 o_rd_valid  out  1  committed slot available to consumer.
REQ-013 o_rd_slot  out  2  slot index offered/held by consumer.
REQ-014 i_rd_ack  in  1  one-cycle pulse; consumer takes offered slot.
REQ-015 i_rd_done  in  1  one-cycle pulse; consumer finished, slot freed.
REQ-016 o_level  out  3  committed, unreleased slots, 0..4.
REQ-017 o_full / o_empty  out  1 each  o_level==4 / o_level==0.

Function
REQ-018 Write FSM states W_IDLE, W_FILL; read FSM states R_IDLE, R_OFFER, R_BUSY; both registered.
REQ-019 wr_ptr, rd_ptr 2-bit, wrap 3->0 by natural overflow; slots handed out and consumed strictly in order.
REQ-020 W_IDLE: i_wr_req=1 and o_full=0 -> next cycle o_wr_grant=1, o_wr_slot=wr_ptr, enter W_FILL; o_full=1 -> hold W_IDLE, no grant.
REQ-021 W_FILL: i_wr_done -> wr_ptr+1, o_wr_seq+1, level+1, return W_IDLE next cycle.
REQ-022 W_FILL: i_wr_abort -> W_IDLE, wr_ptr, o_wr_seq, level unchanged (slot reused by next grant).
REQ-023 W_FILL: timeout counter starts 0 at grant, increments per cycle; reaching TIMEOUT_CYC-1 without done/abort -> o_wr_timeout pulse, treated as abort.
REQ-024 W_FILL: i_wr_done and i_wr_abort same cycle -> done wins; done on timeout cycle -> done wins, no o_wr_timeout.
REQ-025 i_wr_done/i_wr_abort outside W_FILL ignored.
REQ-026 R_IDLE: level>0 -> R_OFFER next cycle, o_rd_valid=1, o_rd_slot=rd_ptr.
REQ-027 R_OFFER: i_rd_ack -> R_BUSY, o_rd_valid=0, o_rd_slot held.
REQ-028 R_BUSY: i_rd_done -> rd_ptr+1, level-1, R_IDLE.
REQ-029 i_rd_ack outside R_OFFER and i_rd_done outside R_BUSY ignored.
REQ-030 Commit and release same cycle -> level unchanged, both pointers advance.
REQ-031 Level never exceeds 4 or underflows 0; full blocks grant only, empty blocks offer only.
REQ-032 Write slot never equals a committed unreleased slot (guaranteed by REQ-020 full check).
REQ-033 o_wr_seq 32-bit, wraps 32'hFFFFFFFF->0.

Reset
REQ-034 i_rst=1 at any clock edge, including mid-fill or mid-read: both FSMs to idle, wr_ptr=rd_ptr=0, o_wr_seq=0, level=0, timeout counter=0.
REQ-035 Reset values: o_wr_grant=0, o_wr_slot=0, o_wr_timeout=0, o_rd_valid=0, o_rd_slot=0, o_level=0, o_full=0, o_empty=1.
REQ-036 First cycle after reset release: grant possible if i_wr_req=1 (grant appears next cycle).

Verification
REQ-037 After reset, 4 req/done cycles, no consumer -> slots 0,1,2,3 granted, seq 0..3, o_level=4, o_full=1; 5th req gets no grant.
REQ-038 Full; consumer ack+done on slot 0 -> o_level=3, next pending req granted slot 0 with o_wr_seq=4.
REQ-039 Grant slot 2, i_wr_abort -> next grant again slot 2, o_wr_seq unchanged, o_level unchanged.
REQ-040 TIMEOUT_CYC=16, grant, no done -> o_wr_timeout pulse 15 cycles after grant cycle, W_IDLE, slot reissued.
REQ-041 o_level=2, i_wr_done and i_rd_done same cycle -> o_level stays 2, wr_ptr and rd_ptr both +1.
REQ-042 i_rst asserted in R_BUSY with o_level=3 -> next cycle all outputs at REQ-035 values; subsequent grant is slot 0, seq 0.
